// File: rtl/grey_col_pipe_p_if.sv
// Column handshake bundle: req/rdy pair, last-of-frame flag and column data.
// master drives rdy/last_col/data, slave drives req.
interface grey_col_pipe_p_if #(
   parameter int W = 8
);
   logic         req;
   logic         rdy;
   logic         last_col;
   logic [W-1:0] data;

   modport master (
      output rdy, last_col, data,
      input  req
   );

   modport slave (
      input  rdy, last_col, data,
      output req
   );
endinterface

// File: rtl/grey_col_pipe_p.sv
// Column-stream RGB888 -> greyscale stage, LANES shared converters,
// double-buffered output so the next column converts while one waits.
module grey_col_pipe_p #(
   parameter int ROWS  = 256,
   parameter int LANES = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              init,
   input  logic [1:0]        mode,
   grey_col_pipe_p_if.slave  col_in,
   grey_col_pipe_p_if.master col_out
);
   localparam int N  = ROWS / LANES;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int IW = ROWS * 24;
   localparam int OW = ROWS * 8;

   if (ROWS % LANES != 0) begin : g_bad_lanes
      $error("grey_col_pipe_p: ROWS must be a multiple of LANES");
   end

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      WAIT
   } state_t;

   state_t          state;
   logic [CW-1:0]   chunk;
   logic            run;
   logic [1:0]      wmode;
   logic            wlast;
   logic [IW-1:0]   wdata;
   logic [OW-1:0]   wres;
   logic [OW-1:0]   res_nx;
   logic            out_valid;
   logic            olast;
   logic [OW-1:0]   odata;
   logic            req;
   logic            in_xfer;
   logic            out_xfer;
   logic            last_chunk;

   function automatic logic [7:0] grey(
      input logic [23:0] px,
      input logic [1:0]  m
   );
      logic [17:0] r, g, b, acc;
      r   = {10'd0, px[23:16]};
      g   = {10'd0, px[15:8]};
      b   = {10'd0, px[7:0]};
      acc = '0;
      unique case (m)
         2'd0: acc = (r >> 2) + (g >> 1) + (b >> 2);
         2'd1: acc = (18'd77 * r + 18'd150 * g + 18'd29 * b) >> 8;
         2'd2: acc = ((r + g + b) * 18'd171) >> 9;
         2'd3: acc = g;
      endcase
      return acc[7:0];
   endfunction

   // run keeps req low while reset is held and for the release cycle
   assign req        = run && (state == IDLE);
   assign in_xfer    = req && col_in.rdy;
   assign out_xfer   = out_valid && col_out.req;
   assign last_chunk = (chunk == CW'(N - 1));

   assign col_in.req       = req;
   assign col_out.rdy      = out_valid;
   assign col_out.last_col = olast;
   assign col_out.data     = odata;

   always_comb begin
      res_nx = wres;
      for (int l = 0; l < LANES; l++) begin
         res_nx[(int'(chunk) * LANES + l) * 8 +: 8] =
            grey(wdata[(int'(chunk) * LANES + l) * 24 +: 24], wmode);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         chunk     <= '0;
         run       <= 1'b0;
         wmode     <= '0;
         wlast     <= 1'b0;
         wdata     <= '0;
         wres      <= '0;
         out_valid <= 1'b0;
         olast     <= 1'b0;
         odata     <= '0;
      end else if (init) begin
         state     <= IDLE;
         chunk     <= '0;
         run       <= 1'b1;
         wmode     <= '0;
         wlast     <= 1'b0;
         wdata     <= '0;
         wres      <= '0;
         out_valid <= 1'b0;
         olast     <= 1'b0;
         odata     <= '0;
      end else begin
         run <= 1'b1;
         if (out_xfer) out_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (in_xfer) begin
                  wdata <= col_in.data;
                  wlast <= col_in.last_col;
                  wmode <= mode;
                  chunk <= '0;
                  state <= CONV;
               end
            end
            CONV: begin
               wres  <= res_nx;
               chunk <= chunk + CW'(1);
               if (last_chunk) begin
                  if (!out_valid || out_xfer) begin
                     odata     <= res_nx;
                     olast     <= wlast;
                     out_valid <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (!out_valid || out_xfer) begin
                  odata     <= wres;
                  olast     <= wlast;
                  out_valid <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_grey_col_pipe_p.sv
// Scoreboard bench for grey_col_pipe_p: stimulus pushes expected columns,
// a negedge monitor pops and compares on each output transfer.
module tb_grey_col_pipe_p;
   localparam int ROWS  = 256;
   localparam int LANES = 16;
   localparam int IW    = ROWS * 24;
   localparam int OW    = ROWS * 8;

   typedef struct packed {
      logic          last;
      logic [OW-1:0] data;
   } exp_t;

   logic       clock   = 1'b0;
   logic       reset_n = 1'b0;
   logic       init    = 1'b0;
   logic [1:0] mode    = 2'd0;

   grey_col_pipe_p_if #(.W(IW)) in_if ();
   grey_col_pipe_p_if #(.W(OW)) out_if ();

   grey_col_pipe_p #(
      .ROWS  (ROWS),
      .LANES (LANES)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .init    (init),
      .mode    (mode),
      .col_in  (in_if),
      .col_out (out_if)
   );

   always #5 clock = ~clock;

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input bit ok, input string name,
                      input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // monitor: a transfer happens on the next posedge when rdy & req
   always @(negedge clock) begin
      if (reset_n && !init && out_if.rdy && out_if.req) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got a column, expected none");
         end else begin
            int bad;
            mon_e = q.pop_front();
            bad = -1;
            for (int i = ROWS - 1; i >= 0; i--)
               if (out_if.data[i*8 +: 8] !== mon_e.data[i*8 +: 8]) bad = i;
            checks++;
            if (bad >= 0) begin
               errors++;
               $display("FAIL col_data: pixel %0d got %0d, expected %0d",
                        bad, out_if.data[bad*8 +: 8], mon_e.data[bad*8 +: 8]);
            end
            checks++;
            if (out_if.last_col !== mon_e.last) begin
               errors++;
               $display("FAIL col_last: got %0b, expected %0b",
                        out_if.last_col, mon_e.last);
            end
         end
      end
   end

   function automatic logic [IW-1:0] uni(input logic [23:0] rgb);
      logic [IW-1:0] d;
      for (int i = 0; i < ROWS; i++) d[i*24 +: 24] = rgb;
      return d;
   endfunction

   function automatic logic [OW-1:0] exp_uni(input logic [7:0] v);
      logic [OW-1:0] d;
      for (int i = 0; i < ROWS; i++) d[i*8 +: 8] = v;
      return d;
   endfunction

   // pixel i = (i,i,i) when grey, else (0, i or 255-i, 0)
   function automatic logic [IW-1:0] ramp(input bit grey, input bit inv);
      logic [IW-1:0] d;
      logic [7:0]    v;
      for (int i = 0; i < ROWS; i++) begin
         v = inv ? 8'(255 - i) : 8'(i);
         d[i*24 +: 24] = grey ? {v, v, v} : {8'd0, v, 8'd0};
      end
      return d;
   endfunction

   function automatic logic [OW-1:0] exp_ramp(input bit inv);
      logic [OW-1:0] d;
      for (int i = 0; i < ROWS; i++) d[i*8 +: 8] = inv ? 8'(255 - i) : 8'(i);
      return d;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [IW-1:0] d, input logic [1:0] m,
                       input logic l, input logic [OW-1:0] ed);
      int n;
      n = 0;
      while (!in_if.req && n < 300) begin
         tick();
         n++;
      end
      chk(in_if.req === 1'b1, "accept_timeout", 64'(in_if.req), 64'd1);
      if (in_if.req === 1'b1) begin
         in_if.data     = d;
         in_if.last_col = l;
         in_if.rdy      = 1'b1;
         mode           = m;
         tick();
         q.push_back({l, ed});
         in_if.rdy      = 1'b0;
         in_if.data     = ~d;
         in_if.last_col = ~l;
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      chk(q.size() == 0, name, 64'(q.size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      in_if.rdy      = 1'b0;
      in_if.last_col = 1'b0;
      in_if.data     = '0;
      out_if.req     = 1'b0;

      // 1. reset with random inputs
      for (int k = 0; k < 5; k++) begin
         in_if.rdy      = 1'($urandom);
         in_if.last_col = 1'($urandom);
         in_if.data     = {ROWS{24'($urandom)}};
         out_if.req     = 1'($urandom);
         mode           = 2'($urandom);
         tick();
      end
      chk(out_if.rdy === 1'b0, "rst_rdy_out", 64'(out_if.rdy), 64'd0);
      chk(out_if.last_col === 1'b0, "rst_last_out", 64'(out_if.last_col), 64'd0);
      chk(out_if.data === '0, "rst_data_out", 64'(out_if.data), 64'd0);
      chk(in_if.req === 1'b0, "rst_req_out", 64'(in_if.req), 64'd0);
      in_if.rdy  = 1'b0;
      out_if.req = 1'b1;
      reset_n    = 1'b1;
      tick();
      chk(in_if.req === 1'b1, "rel_req_out", 64'(in_if.req), 64'd1);
      chk(out_if.rdy === 1'b0, "rel_rdy_out", 64'(out_if.rdy), 64'd0);

      // 2. BT.601 grey ramp, latency
      send(ramp(1'b1, 1'b0), 2'd1, 1'b0, exp_ramp(1'b0));
      cnt = 1;
      while (!out_if.rdy && cnt < 100) begin
         tick();
         cnt++;
      end
      chk(cnt == 17, "latency", 64'(cnt), 64'd17);
      drain("drain_t2");

      // 3. other modes; mode toggles during CONV are ignored
      send(uni(24'hFFFFFF), 2'd0, 1'b0, exp_uni(8'd253));
      for (int k = 0; k < 6; k++) begin
         mode = 2'(k);
         tick();
      end
      send(uni(24'h030000), 2'd2, 1'b0, exp_uni(8'd1));
      send(uni({8'd10, 8'd200, 8'd30}), 2'd3, 1'b0, exp_uni(8'd200));
      send(uni(24'hFFFFFF), 2'd1, 1'b0, exp_uni(8'd255));
      send(uni(24'hFFFFFF), 2'd2, 1'b0, exp_uni(8'd255));
      drain("drain_t3");

      // 4. backpressure: second column parks in WAIT
      out_if.req = 1'b0;
      send(ramp(1'b0, 1'b0), 2'd3, 1'b0, exp_ramp(1'b0));
      send(ramp(1'b0, 1'b1), 2'd3, 1'b0, exp_ramp(1'b1));
      for (int k = 0; k < 20; k++) tick();
      chk(in_if.req === 1'b0, "wait_req_out", 64'(in_if.req), 64'd0);
      chk(out_if.rdy === 1'b1, "wait_rdy_out", 64'(out_if.rdy), 64'd1);
      chk(q.size() == 2, "wait_queued", 64'(q.size()), 64'd2);
      out_if.req = 1'b1;
      drain("drain_t4");

      // 5. last_col flag travels with data and holds afterwards
      send(uni({8'd0, 8'h5A, 8'd0}), 2'd3, 1'b1, exp_uni(8'h5A));
      drain("drain_t5a");
      chk(out_if.rdy === 1'b0, "last_rdy_out", 64'(out_if.rdy), 64'd0);
      chk(out_if.last_col === 1'b1, "last_hold", 64'(out_if.last_col), 64'd1);
      send(uni({8'd0, 8'h33, 8'd0}), 2'd3, 1'b0, exp_uni(8'h33));
      for (int k = 0; k < 5; k++) tick();
      chk(out_if.last_col === 1'b1, "last_hold_conv", 64'(out_if.last_col), 64'd1);
      drain("drain_t5b");

      // 6. init during chunk 7 discards the column
      send(ramp(1'b1, 1'b1), 2'd1, 1'b0, exp_ramp(1'b1));
      for (int k = 0; k < 7; k++) tick();
      init = 1'b1;
      tick();
      init = 1'b0;
      void'(q.pop_back());
      chk(out_if.rdy === 1'b0, "init_rdy_out", 64'(out_if.rdy), 64'd0);
      chk(in_if.req === 1'b1, "init_req_out", 64'(in_if.req), 64'd1);
      for (int k = 0; k < 20; k++) tick();
      chk(out_if.rdy === 1'b0, "init_no_output", 64'(out_if.rdy), 64'd0);
      send(uni(24'h030000), 2'd2, 1'b0, exp_uni(8'd1));
      drain("drain_t6");

      for (int k = 0; k < 3; k++) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
